bypass_req_ctrl: RTL
====================

BYPASS_REQ_CTRL -- requirements
Module: bypass_req_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4, meaning consecutive synchronized-high cycles needed to accept a button press (legal range 1..255).
REQ-002 Parameter ACK_STATE, default 2'b11, meaning the downstream FSM state code that acknowledges and consumes the bypass request.
REQ-003 Parameter TIMEOUT_CYCLES, default 64, meaning cycles an unacknowledged request may stay asserted (used only under REQ-022).
REQ-004 clk  input  1  single system clock; all flops on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 btn_in  input  1  asynchronous raw bypass button, active-high, may bounce.
REQ-007 fsm_state  input  2  current state code of the downstream Moore FSM.
REQ-008 bypass  output  1  registered bypass request driven into the downstream FSM.
REQ-009 busy  output  1  high whenever the controller is not in IDLE.
REQ-010 ack_pulse  output  1  one-cycle pulse when a request is acknowledged.

Function
REQ-011 btn_in SHALL pass through a 2-flop synchronizer; btn_sync is the second-stage output, and no other logic SHALL sample btn_in.
REQ-012 The FSM SHALL have exactly four states: IDLE, DEBOUNCE, ARMED, RELEASE.
REQ-013 IDLE: if btn_sync=1, go to DEBOUNCE and clear the 8-bit debounce counter; otherwise stay.
REQ-014 DEBOUNCE: if btn_sync=0, go to IDLE; else if counter==DEBOUNCE_CYCLES-1, go to ARMED; else increment the counter.
REQ-015 ARMED: if fsm_state==ACK_STATE, go to RELEASE and assert ack_pulse for that one cycle; otherwise stay.
REQ-016 RELEASE: go to IDLE only when btn_sync=0, so that a held button never re-arms.
REQ-017 Outputs SHALL be registered: bypass=1 iff state is ARMED, and busy=1 iff state is not IDLE.
REQ-018 Latency: with btn_in stable high from edge k, bypass SHALL rise after edge k+2+DEBOUNCE_CYCLES.
REQ-019 If fsm_state already equals ACK_STATE on the first ARMED cycle, the request SHALL be acknowledged at the next edge, giving bypass high for exactly one cycle.
REQ-020 A btn_in glitch shorter than DEBOUNCE_CYCLES synchronized cycles SHALL never assert bypass.

Reset
REQ-021 While reset=0 at a rising edge, the state SHALL go to IDLE and the synchronizer flops, debounce counter, timeout counter, bypass, busy and ack_pulse SHALL all clear to 0; this applies from any state, including mid-debounce and ARMED.

Configuration
REQ-022 With macro BYPASS_TIMEOUT_EN defined:
- add output timeout_pulse (1 bit);
- an ARMED stay of TIMEOUT_CYCLES cycles SHALL force RELEASE with a one-cycle timeout_pulse and no ack_pulse;
- ack SHALL win over timeout on the same edge.
REQ-023 With BYPASS_TIMEOUT_EN undefined, there SHALL be no timeout port and no timeout counter, and ARMED SHALL persist until acknowledged.

Structure
REQ-024 Package bypass_req_pkg SHALL hold the state enum (2 bits), the FSM state-code width constant (2) and the debounce counter width constant (8).
REQ-025 The synchronizer SHALL be a sub-module named sync_2ff, instantiated once.

Verification
REQ-026 Reset release, btn_in=0 for 20 cycles -> bypass=0, busy=0, ack_pulse=0 throughout.
REQ-027 btn_in high 2 cycles then low (DEBOUNCE_CYCLES=4) -> bypass never asserts; busy returns to 0 within 5 cycles.
REQ-028 btn_in held high from edge 10, fsm_state=2'b00 -> bypass rises after edge 16; then fsm_state=2'b11 at edge 30 -> bypass falls after edge 30 with ack_pulse high for that one cycle; button still held -> busy stays 1 until btn_in low plus 2 cycles.
REQ-029 Reset driven low at edge 5 while in ARMED -> all outputs 0 after that edge; after reset releases with btn_in still high, bypass re-asserts only after the full debounce interval.
REQ-030 BYPASS_TIMEOUT_EN defined, TIMEOUT_CYCLES=64, fsm_state never 2'b11 -> bypass high for exactly 64 cycles, timeout_pulse=1 once, ack_pulse=0.
REQ-031 BYPASS_TIMEOUT_EN defined, fsm_state=2'b11 on the same edge the timeout expires -> ack_pulse=1, timeout_pulse=0.

Source files
------------

// File: rtl/bypass_req_pkg.sv
// Shared definitions for the bypass request controller.
//   STATE_CODE_W : width of the downstream FSM state code (fsm_state / ACK_STATE)
//   DEB_CNT_W    : width of the debounce counter
//   ctrl_state_e : controller states IDLE, DEBOUNCE, ARMED, RELEASE
package bypass_req_pkg;

  localparam int STATE_CODE_W = 2;
  localparam int DEB_CNT_W    = 8;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DEBOUNCE = 2'b01,
    ARMED    = 2'b10,
    RELEASE  = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/bypass_req_ctrl_sync_2ff.sv
// Two-flop synchronizer for the asynchronous bypass button.
// Ports:
//   clk   : system clock
//   reset : synchronous active-low reset, clears both stages
//   d     : asynchronous input
//   q     : second-stage (synchronized) output
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [1:0] stage_reg;

  always_ff @(posedge clk) begin
    if (!reset) begin
      stage_reg <= 2'b00;
    end else begin
      stage_reg <= {stage_reg[0], d};
    end
  end

  assign q = stage_reg[1];

endmodule

// File: rtl/bypass_req_ctrl.sv
// Bypass request controller: debounces a raw button and holds a registered
// bypass request toward a downstream Moore FSM until that FSM reaches
// ACK_STATE. A button that stays held after the acknowledge never re-arms.
//
// Parameters:
//   DEBOUNCE_CYCLES : consecutive synchronized-high cycles to accept a press (1..255)
//   ACK_STATE       : downstream state code that consumes the request
//   TIMEOUT_CYCLES  : maximum ARMED residency when BYPASS_TIMEOUT_EN is defined
// Ports:
//   clk           : system clock, rising edge
//   reset         : synchronous active-low reset
//   btn_in        : asynchronous raw button, active-high, may bounce
//   fsm_state     : current downstream FSM state code
//   bypass        : registered request, high while ARMED
//   busy          : registered, high while not IDLE
//   ack_pulse     : one-cycle pulse when the request is acknowledged
//   timeout_pulse : (BYPASS_TIMEOUT_EN only) one-cycle pulse when an ARMED
//                   request is abandoned after TIMEOUT_CYCLES cycles
// Configuration macro: BYPASS_TIMEOUT_EN (undefined by default; without it
// the request stays ARMED until acknowledged).
module bypass_req_ctrl
  import bypass_req_pkg::*;
#(
  parameter int unsigned              DEBOUNCE_CYCLES = 4,
  parameter logic [STATE_CODE_W-1:0]  ACK_STATE       = 2'b11,
  parameter int unsigned              TIMEOUT_CYCLES  = 64
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     btn_in,
  input  logic [STATE_CODE_W-1:0]  fsm_state,
  output logic                     bypass,
  output logic                     busy,
  output logic                     ack_pulse
`ifdef BYPASS_TIMEOUT_EN
  ,
  output logic                     timeout_pulse
`endif
);

  // Terminal count: the counter starts at 0 on entry to DEBOUNCE, so the
  // press is accepted on the DEBOUNCE_CYCLES-th consecutive high sample.
  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEBOUNCE_CYCLES - 1);

  // Out-of-range configurations elaborate this marker block so they are
  // visible in the elaborated hierarchy.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255 || TIMEOUT_CYCLES < 1) begin : g_cfg_out_of_range
  end

  logic                 btn_sync;
  ctrl_state_e          state_reg, state_next;
  logic [DEB_CNT_W-1:0] deb_cnt_reg, deb_cnt_next;
  logic                 bypass_reg, busy_reg, ack_pulse_reg;
  logic                 ack_next;

`ifdef BYPASS_TIMEOUT_EN
  localparam int             TMO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic             timeout_pulse_reg, timeout_next;
`endif

  // The synchronizer is the only consumer of btn_in.
  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_sync)
  );

  always_comb begin
    state_next   = state_reg;
    deb_cnt_next = deb_cnt_reg;
    ack_next     = 1'b0;
`ifdef BYPASS_TIMEOUT_EN
    tmo_cnt_next = tmo_cnt_reg;
    timeout_next = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (btn_sync) begin
          state_next   = DEBOUNCE;
          deb_cnt_next = '0;
        end
      end
      DEBOUNCE: begin
        if (!btn_sync) begin
          state_next = IDLE;
        end else if (deb_cnt_reg == DEB_LAST) begin
          state_next = ARMED;
        end else begin
          deb_cnt_next = deb_cnt_reg + 8'd1;
        end
      end
      ARMED: begin
        // Acknowledge is checked first so it wins over a coincident timeout.
        if (fsm_state == ACK_STATE) begin
          state_next = RELEASE;
          ack_next   = 1'b1;
        end
`ifdef BYPASS_TIMEOUT_EN
        else if (tmo_cnt_reg == TMO_LAST) begin
          state_next   = RELEASE;
          timeout_next = 1'b1;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TMO_W'(1);
        end
`endif
      end
      RELEASE: begin
        // Wait for the button to be let go so a held press cannot re-arm.
        if (!btn_sync) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
`ifdef BYPASS_TIMEOUT_EN
    // Counter only runs while ARMED, so it is always zero on entry.
    if (state_reg != ARMED) begin
      tmo_cnt_next = '0;
    end
`endif
  end

  // Outputs are registered from the next state so they line up with the
  // state register rather than lagging it by a cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      deb_cnt_reg   <= '0;
      bypass_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      ack_pulse_reg <= 1'b0;
`ifdef BYPASS_TIMEOUT_EN
      tmo_cnt_reg       <= '0;
      timeout_pulse_reg <= 1'b0;
`endif
    end else begin
      state_reg     <= state_next;
      deb_cnt_reg   <= deb_cnt_next;
      bypass_reg    <= (state_next == ARMED);
      busy_reg      <= (state_next != IDLE);
      ack_pulse_reg <= ack_next;
`ifdef BYPASS_TIMEOUT_EN
      tmo_cnt_reg       <= tmo_cnt_next;
      timeout_pulse_reg <= timeout_next;
`endif
    end
  end

  assign bypass    = bypass_reg;
  assign busy      = busy_reg;
  assign ack_pulse = ack_pulse_reg;
`ifdef BYPASS_TIMEOUT_EN
  assign timeout_pulse = timeout_pulse_reg;
`endif

endmodule
